ascon_round_ctrl: RTL and testbench

Sequencer for the Ascon permutation datapath in the clock domain. It owns the 320-bit Ascon state (S_0..S_4) and accepts an operation code and start request from the SPI subnode. It applies the operation's pre-XOR, steps the round function one round per clock for 12 (p^a) or 6 (p^b) rounds, applies the post-XOR, and signals completion. The state words feed back to the SPI subnode for readout.

---
 rtl/ascon_pkg.sv | 55 +++++
 rtl/ascon_round.sv | 47 ++++
 rtl/ascon_round_ctrl.sv | 155 +++++++++++++++
 tb/tb_ascon_round_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// Shared encodings, constants and helpers for the Ascon round sequencer.
package ascon_pkg;

    localparam int unsigned W_WORD  = 64;
    localparam int unsigned W_STATE = 5 * W_WORD;
    localparam int unsigned W_RND   = 4;
    localparam int unsigned W_MODE  = 3;
    localparam int unsigned W_HALF  = 128;

    typedef enum logic [W_MODE-1:0] {
        OP_NONE   = 3'd0,
        OP_INIT   = 3'd1,
        OP_ABSORB = 3'd2,
        OP_FINAL  = 3'd3,
        OP_PERM_A = 3'd4,
        OP_PERM_B = 3'd5
    } op_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ROUND = 2'd2,
        ST_POST  = 2'd3
    } fsm_state_e;

    // Five 64-bit lanes, S_0 in the most significant position.
    typedef struct packed {
        logic [W_WORD-1:0] x0;
        logic [W_WORD-1:0] x1;
        logic [W_WORD-1:0] x2;
        logic [W_WORD-1:0] x3;
        logic [W_WORD-1:0] x4;
    } ascon_state_t;

    localparam logic [W_WORD-1:0] ASCON_IV = 64'h80400c0600000000;
    localparam logic [W_RND-1:0]  PA_START = 4'd0;
    localparam logic [W_RND-1:0]  PB_START = 4'd6;
    localparam logic [W_RND-1:0]  LAST_RND = 4'd11;

    function automatic logic [7:0] round_const(input logic [W_RND-1:0] rnd);
        return {4'(4'd15 - rnd), rnd};
    endfunction

    function automatic logic mode_legal(input logic [W_MODE-1:0] mode);
        return (mode >= 3'(OP_INIT)) && (mode <= 3'(OP_PERM_B));
    endfunction

    function automatic logic [W_WORD-1:0] ror64(input logic [W_WORD-1:0] x,
                                                input int unsigned      n);
        logic [2*W_WORD-1:0] xx;
        xx = {x, x} >> n;
        return xx[W_WORD-1:0];
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, S-box layer, linear layer.
module ascon_round
    import ascon_pkg::*;
(
    input  logic [W_STATE-1:0] state_in,
    input  logic [W_RND-1:0]   rnd,
    output logic [W_STATE-1:0] state_c
);

    ascon_state_t s_in;
    ascon_state_t s_out;
    logic [W_WORD-1:0] a0, a1, a2, a3, a4;
    logic [W_WORD-1:0] b0, b1, b2, b3, b4;
    logic [W_WORD-1:0] c0, c1, c2, c3, c4;

    assign s_in = ascon_state_t'(state_in);

    always_comb begin
        // Constant addition and the input XOR stage of the S-box.
        a0 = s_in.x0 ^ s_in.x4;
        a1 = s_in.x1;
        a2 = (s_in.x2 ^ {56'd0, round_const(rnd)}) ^ s_in.x1;
        a3 = s_in.x3;
        a4 = s_in.x4 ^ s_in.x3;

        b0 = a0 ^ (~a1 & a2);
        b1 = a1 ^ (~a2 & a3);
        b2 = a2 ^ (~a3 & a4);
        b3 = a3 ^ (~a4 & a0);
        b4 = a4 ^ (~a0 & a1);

        c1 = b1 ^ b0;
        c0 = b0 ^ b4;
        c3 = b3 ^ b2;
        c2 = ~b2;
        c4 = b4;

        s_out.x0 = c0 ^ ror64(c0, 19) ^ ror64(c0, 28);
        s_out.x1 = c1 ^ ror64(c1, 61) ^ ror64(c1, 39);
        s_out.x2 = c2 ^ ror64(c2, 1)  ^ ror64(c2, 6);
        s_out.x3 = c3 ^ ror64(c3, 10) ^ ror64(c3, 17);
        s_out.x4 = c4 ^ ror64(c4, 7)  ^ ror64(c4, 41);
    end

    assign state_c = W_STATE'(s_out);

endmodule

// File: rtl/ascon_round_ctrl.sv
// Ascon permutation sequencer: owns the 320-bit state, runs p^a / p^b with pre/post XOR.
// Define ASCON_SYNC_EN to pass op_ready through a 2-flop synchronizer.
module ascon_round_ctrl
    import ascon_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          op_ready,
    input  logic [2:0]    op_mode,
    input  logic [127:0]  key_128b,
    input  logic [127:0]  nonce_128b,
    input  logic [127:0]  data_128b,
    output logic [63:0]   S_0_reg,
    output logic [63:0]   S_1_reg,
    output logic [63:0]   S_2_reg,
    output logic [63:0]   S_3_reg,
    output logic [63:0]   S_4_reg,
    output logic          busy,
    output logic          done,
    output logic          err
);

    fsm_state_e           state_q, state_d;
    op_mode_e             mode_q, mode_d;
    logic [W_RND-1:0]     rnd_q, rnd_d;
    logic [W_STATE-1:0]   s_q, s_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 hist_q, hist_d;
    logic                 op_lvl_c;
    logic                 start_c;
    logic [W_STATE-1:0]   round_c;
    logic                 unused_data_c;

    assign unused_data_c = ^data_128b[63:0];

`ifdef ASCON_SYNC_EN
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    assign sync1_d = op_ready;
    assign sync2_d = sync1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign op_lvl_c = sync2_q;
`else
    assign op_lvl_c = op_ready;
`endif

    assign hist_d  = op_lvl_c;
    assign start_c = op_lvl_c & ~hist_q;

    ascon_round u_round (
        .state_in (s_q),
        .rnd      (rnd_q),
        .state_c  (round_c)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        rnd_d   = rnd_q;
        s_d     = s_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    if (mode_legal(op_mode)) begin
                        mode_d  = op_mode_e'(op_mode);
                        state_d = ST_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                case (mode_q)
                    OP_INIT:   s_d = {ASCON_IV, key_128b, nonce_128b};
                    OP_ABSORB: s_d[W_STATE-1 -: W_WORD] = s_q[W_STATE-1 -: W_WORD] ^ data_128b[127:64];
                    OP_FINAL:  s_d[W_STATE-W_WORD-1 -: W_HALF] = s_q[W_STATE-W_WORD-1 -: W_HALF] ^ key_128b;
                    default:   s_d = s_q;
                endcase
                rnd_d   = ((mode_q == OP_ABSORB) || (mode_q == OP_PERM_B)) ? PB_START : PA_START;
                state_d = ST_ROUND;
            end
            ST_ROUND: begin
                // An out-of-range count bails straight to POST without touching the state.
                if (rnd_q > LAST_RND) begin
                    state_d = ST_POST;
                end else begin
                    s_d = round_c;
                    if (rnd_q == LAST_RND) begin
                        state_d = ST_POST;
                    end else begin
                        rnd_d = rnd_q + 4'd1;
                    end
                end
            end
            ST_POST: begin
                if ((mode_q == OP_INIT) || (mode_q == OP_FINAL)) begin
                    s_d[W_HALF-1:0] = s_q[W_HALF-1:0] ^ key_128b;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_d = (state_d != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= OP_NONE;
            rnd_q   <= '0;
            s_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            rnd_q   <= rnd_d;
            s_q     <= s_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            hist_q  <= hist_d;
        end
    end

    assign S_0_reg = s_q[319:256];
    assign S_1_reg = s_q[255:192];
    assign S_2_reg = s_q[191:128];
    assign S_3_reg = s_q[127:64];
    assign S_4_reg = s_q[63:0];
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_ascon_round_ctrl.sv
// Self-checking bench for ascon_round_ctrl against an S-box-table Ascon model.
module tb_ascon_round_ctrl;

`ifdef ASCON_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic         clk;
    logic         rst;
    logic         op_ready;
    logic [2:0]   op_mode;
    logic [127:0] key_128b;
    logic [127:0] nonce_128b;
    logic [127:0] data_128b;
    logic [63:0]  S_0_reg, S_1_reg, S_2_reg, S_3_reg, S_4_reg;
    logic         busy, done, err;

    ascon_round_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .op_ready   (op_ready),
        .op_mode    (op_mode),
        .key_128b   (key_128b),
        .nonce_128b (nonce_128b),
        .data_128b  (data_128b),
        .S_0_reg    (S_0_reg),
        .S_1_reg    (S_1_reg),
        .S_2_reg    (S_2_reg),
        .S_3_reg    (S_3_reg),
        .S_4_reg    (S_4_reg),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   mode;
        logic [127:0] key;
        logic [127:0] nonce;
        logic [127:0] data;
        int           busy_len;
    } vec_t;

    typedef struct {
        logic [319:0] s;
        int busy_len;
        int n_done;
        int n_err;
        int busy_at;
        int done_at;
        int err_at;
    } exp_t;

    exp_t         sb[$];
    vec_t         vecs[10];
    logic [4:0]   sbox[32];
    logic [319:0] m_s;
    int           n_pass;
    int           n_total;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_total++;
        if (act !== want) $display("FAIL %s: got %h want %h", nm, act, want);
        else n_pass++;
    endtask

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] m_round(input logic [319:0] s, input int r);
        logic [63:0] x[5];
        logic [4:0]  col, o;
        for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
        x[2][7:0] = x[2][7:0] ^ 8'(((15 - r) << 4) | r);
        for (int b = 0; b < 64; b++) begin
            col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
            o   = sbox[col];
            x[0][b] = o[4]; x[1][b] = o[3]; x[2][b] = o[2]; x[3][b] = o[1]; x[4][b] = o[0];
        end
        x[0] = x[0] ^ ror(x[0], 19) ^ ror(x[0], 28);
        x[1] = x[1] ^ ror(x[1], 61) ^ ror(x[1], 39);
        x[2] = x[2] ^ ror(x[2], 1)  ^ ror(x[2], 6);
        x[3] = x[3] ^ ror(x[3], 10) ^ ror(x[3], 17);
        x[4] = x[4] ^ ror(x[4], 7)  ^ ror(x[4], 41);
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [319:0] m_perm(input logic [319:0] s, input int first);
        logic [319:0] t = s;
        for (int r = first; r < 12; r++) t = m_round(t, r);
        return t;
    endfunction

    function automatic logic [319:0] m_op(input logic [319:0] s, input logic [2:0] m,
                                          input logic [127:0] k, input logic [127:0] n,
                                          input logic [127:0] d);
        logic [319:0] t = s;
        case (m)
            3'd1: begin
                t = m_perm({64'h80400c0600000000, k, n}, 0);
                t[127:0] = t[127:0] ^ k;
            end
            3'd2: begin
                t[319:256] = t[319:256] ^ d[127:64];
                t = m_perm(t, 6);
            end
            3'd3: begin
                t[255:128] = t[255:128] ^ k;
                t = m_perm(t, 0);
                t[127:0] = t[127:0] ^ k;
            end
            3'd4: t = m_perm(t, 0);
            3'd5: t = m_perm(t, 6);
            default: t = s;
        endcase
        return t;
    endfunction

    // Drives one operation, observes 32 cycles, then scores it; regrab>0 re-raises op_ready at that cycle.
    task automatic do_op(input string tag, input logic [2:0] m, input logic [127:0] k,
                         input logic [127:0] n, input logic [127:0] d,
                         input int busy_len, input int regrab);
        exp_t e;
        int nb, nd, ne, fb, fd, fe;
        e.s        = m_op(m_s, m, k, n, d);
        m_s        = e.s;
        e.busy_len = busy_len;
        e.n_done   = (busy_len != 0) ? 1 : 0;
        e.n_err    = (busy_len == 0) ? 1 : 0;
        e.busy_at  = (busy_len != 0) ? 1 + LAT : -1;
        e.done_at  = (busy_len != 0) ? busy_len + 1 + LAT : -1;
        e.err_at   = (busy_len == 0) ? 1 + LAT : -1;
        sb.push_back(e);

        @(negedge clk);
        op_mode = m; key_128b = k; nonce_128b = n; data_128b = d; op_ready = 1'b1;
        nb = 0; nd = 0; ne = 0; fb = -1; fd = -1; fe = -1;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            if (busy) begin nb++; if (fb < 0) fb = c; end
            if (done) begin nd++; if (fd < 0) fd = c; end
            if (err)  begin ne++; if (fe < 0) fe = c; end
            if (regrab > 0 && c == regrab - 1) op_ready = 1'b0;
            if (regrab > 0 && c == regrab)     op_ready = 1'b1;
        end
        op_ready = 1'b0;
        repeat (4) @(negedge clk);

        e = sb.pop_front();
        chk({tag, "_busy_len"}, 64'(nb), 64'(e.busy_len));
        chk({tag, "_n_done"},   64'(nd), 64'(e.n_done));
        chk({tag, "_n_err"},    64'(ne), 64'(e.n_err));
        chk({tag, "_busy_at"},  64'(fb), 64'(e.busy_at));
        chk({tag, "_done_at"},  64'(fd), 64'(e.done_at));
        chk({tag, "_err_at"},   64'(fe), 64'(e.err_at));
        chk({tag, "_S0"}, S_0_reg, e.s[319:256]);
        chk({tag, "_S1"}, S_1_reg, e.s[255:192]);
        chk({tag, "_S2"}, S_2_reg, e.s[191:128]);
        chk({tag, "_S3"}, S_3_reg, e.s[127:64]);
        chk({tag, "_S4"}, S_4_reg, e.s[63:0]);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_S0"}, S_0_reg, 64'd0);
        chk({tag, "_S1"}, S_1_reg, 64'd0);
        chk({tag, "_S2"}, S_2_reg, 64'd0);
        chk({tag, "_S3"}, S_3_reg, 64'd0);
        chk({tag, "_S4"}, S_4_reg, 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_err"},  64'(err),  64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] k1, n1, k2;
        int nd;
        k1 = 128'h000102030405060708090a0b0c0d0e0f;
        n1 = 128'hf0e0d0c0b0a090807060504030201000;
        k2 = 128'hdeadbeefcafef00d0123456789abcdef;
        sbox = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                 5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                 5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                 5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
        vecs[0] = '{3'd5, '0, '0, '0, 8};
        vecs[1] = '{3'd7, k1, n1, '0, 0};
        vecs[2] = '{3'd0, k1, n1, '0, 0};
        vecs[3] = '{3'd1, '0, '0, '0, 14};
        vecs[4] = '{3'd1, k1, n1, '0, 14};
        vecs[5] = '{3'd2, k1, n1, {64'h0123456789abcdef, 64'hffffffffffffffff}, 8};
        vecs[6] = '{3'd3, k1, n1, '0, 14};
        vecs[7] = '{3'd4, k1, n1, '0, 14};
        vecs[8] = '{3'd6, k1, n1, '0, 0};
        vecs[9] = '{3'd5, k1, n1, '0, 8};

        n_pass = 0; n_total = 0; m_s = '0;
        rst = 1'b1; op_ready = 1'b0; op_mode = '0;
        key_128b = '0; nonce_128b = '0; data_128b = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++)
            do_op($sformatf("vec%0d", i), vecs[i].mode, vecs[i].key, vecs[i].nonce,
                  vecs[i].data, vecs[i].busy_len, 0);

        // Re-raised op_ready three cycles into PERM_A must be ignored.
        do_op("regrab", 3'd4, k1, n1, '0, 14, 3);

        // Reset during round 5 of INIT, then a clean INIT.
        @(negedge clk);
        op_mode = 3'd1; key_128b = k2; nonce_128b = n1; op_ready = 1'b1;
        repeat (7 + LAT) @(negedge clk);
        chk("midrst_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk_zero("midrst");
        @(negedge clk);
        rst = 1'b0; op_ready = 1'b0;
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        chk("midrst_no_activity", 64'(nd), 64'd0);
        m_s = '0;
        do_op("post_rst_init", 3'd1, k2, n1, '0, 14, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
